ramp_gen: RTL

Parametrised ramp/pattern generator, the next generation of the single-mode 12-bit ramp counter.
- Advances an output code by a step selected by Y, once per rising edge of the delta tick.
- Supports four ramp modes: wrap, saturate, triangle and down-sawtooth.
- Reports wrap and saturation events.
- Sits between the tick/timing logic and the DAC/pattern output path.

---
 rtl/ramp_pkg.sv | 27 ++
 rtl/ramp_gen_edge_det.sv | 25 ++
 rtl/ramp_gen.sv | 129 ++++++++++++
 3 files changed

// File: rtl/ramp_pkg.sv
// Shared encodings for the ramp generator: mode codes, step-select codes and
// the step-select helper used by the ramp datapath.
package ramp_pkg;

  localparam logic [1:0] MODE_WRAP_UP   = 2'b00;
  localparam logic [1:0] MODE_SAT_UP    = 2'b01;
  localparam logic [1:0] MODE_TRIANGLE  = 2'b10;
  localparam logic [1:0] MODE_WRAP_DOWN = 2'b11;

  localparam logic [1:0] Y_ZERO  = 2'b00;
  localparam logic [1:0] Y_STEP1 = 2'b01;
  localparam logic [1:0] Y_STEP2 = 2'b10;
  localparam logic [1:0] Y_STEP3 = 2'b11;

  function automatic logic [31:0] step_sel(input logic [1:0] y,
                                           input logic [31:0] s1,
                                           input logic [31:0] s2,
                                           input logic [31:0] s3);
    case (y)
      Y_STEP1: return s1;
      Y_STEP2: return s2;
      Y_STEP3: return s3;
      default: return 32'd0;
    endcase
  endfunction

endpackage

// File: rtl/ramp_gen_edge_det.sv
// Rising-edge detector for the delta tick. After reset it stays disarmed until
// the input has been seen low, so a level held through reset never fires.
module edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic in,
  output logic rise
);

  logic r_q;
  logic r_armed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q     <= 1'b0;
      r_armed <= 1'b0;
    end else begin
      r_q <= in;
      if (!in) r_armed <= 1'b1;
    end
  end

  assign rise = in & ~r_q & r_armed;

endmodule

// File: rtl/ramp_gen.sv
// Multi-mode ramp generator: steps the output code once per delta rising edge
// in wrap-up, saturate-up, triangle or wrap-down mode, flagging wraps and saturation.
module ramp_gen
  import ramp_pkg::*;
#(
  parameter int WIDTH   = 12,
  parameter int MAX_VAL = 4095,
  parameter int STEP1   = 1,
  parameter int STEP2   = 16,
  parameter int STEP3   = 1290
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ramp_enb,
  input  logic [1:0]       Y,
  input  logic [1:0]       mode,
  input  logic             delta,
  output logic [WIDTH-1:0] out,
  output logic             dir,
  output logic             wrap_pulse,
  output logic             sat
);

  localparam int W1 = WIDTH + 1;
  localparam logic [W1-1:0]    LP_MAX   = W1'(MAX_VAL);
  localparam logic [W1-1:0]    LP_TOP   = W1'(MAX_VAL + 1);
  localparam logic [WIDTH-1:0] LP_MAX_W = WIDTH'(MAX_VAL);

  logic [WIDTH-1:0] r_out;
  logic             r_dir;
  logic             r_tri;
  logic             r_wrap;
  logic             r_sat;

  logic             w_tick;
  logic [W1-1:0]    w_step;
  logic [W1-1:0]    w_cur;
  logic [W1-1:0]    w_sum;
  logic [WIDTH-1:0] w_out_n;
  logic             w_tri_n;
  logic             w_dir_n;
  logic             w_wrap_n;
  logic             w_sat_n;

  edge_det u_edge_det (
    .clk  (clk),
    .rst_n(rst_n),
    .in   (delta),
    .rise (w_tick)
  );

  assign w_step = W1'(step_sel(Y, 32'(STEP1), 32'(STEP2), 32'(STEP3)));
  assign w_cur  = W1'(r_out);
  assign w_sum  = w_cur + w_step;

  always_comb begin
    w_out_n  = r_out;
    // Triangle direction restarts upward whenever triangle mode is (re)entered.
    w_tri_n  = (mode == MODE_TRIANGLE) ? r_tri : 1'b0;
    w_wrap_n = 1'b0;
    if (w_tick && (w_step != '0)) begin
      case (mode)
        MODE_WRAP_UP: begin
          if (w_sum > LP_MAX) begin
            w_out_n  = WIDTH'(w_sum - LP_TOP);
            w_wrap_n = 1'b1;
          end else begin
            w_out_n = WIDTH'(w_sum);
          end
        end
        MODE_SAT_UP: w_out_n = (w_sum > LP_MAX) ? LP_MAX_W : WIDTH'(w_sum);
        MODE_TRIANGLE: begin
          if (!w_tri_n) begin
            if (w_sum >= LP_MAX) begin
              w_out_n = LP_MAX_W;
              w_tri_n = 1'b1;
            end else begin
              w_out_n = WIDTH'(w_sum);
            end
          end else if (w_cur <= w_step) begin
            w_out_n  = '0;
            w_tri_n  = 1'b0;
            w_wrap_n = 1'b1;
          end else begin
            w_out_n = WIDTH'(w_cur - w_step);
          end
        end
        default: begin
          if (w_cur >= w_step) begin
            w_out_n = WIDTH'(w_cur - w_step);
          end else begin
            w_out_n  = WIDTH'(w_cur + LP_TOP - w_step);
            w_wrap_n = 1'b1;
          end
        end
      endcase
    end
    w_dir_n = (mode == MODE_TRIANGLE) ? w_tri_n : (mode == MODE_WRAP_DOWN);
    w_sat_n = (mode == MODE_SAT_UP) && (w_out_n == LP_MAX_W);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out  <= '0;
      r_dir  <= 1'b0;
      r_tri  <= 1'b0;
      r_wrap <= 1'b0;
      r_sat  <= 1'b0;
    end else if (!ramp_enb) begin
      r_out  <= '0;
      r_dir  <= 1'b0;
      r_tri  <= 1'b0;
      r_wrap <= 1'b0;
      r_sat  <= 1'b0;
    end else begin
      r_out  <= w_out_n;
      r_dir  <= w_dir_n;
      r_tri  <= w_tri_n;
      r_wrap <= w_wrap_n;
      r_sat  <= w_sat_n;
    end
  end

  assign out        = r_out;
  assign dir        = r_dir;
  assign wrap_pulse = r_wrap;
  assign sat        = r_sat;

endmodule
